// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_BUSY = 2'd1,
        INST_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/inst_fetch_buffer.sv
// One-entry tagged instruction buffer: fill from memory, drop on a store to the
// cached address, and report a hit when the tag matches the current PC.
module inst_fetch_buffer
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_en,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  inval_en,
    input  logic [ADDR_WIDTH-1:0] inval_addr,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  hit
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Next-state of the entry; a fill always wins over an invalidate.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end else if (inval_en && (inval_addr == addr_q)) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign data = data_q;
    assign hit  = valid_q && (addr_q == pc);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port variable-latency memory between instruction fetch and
// data access; data has priority and only one transaction is ever outstanding.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [ADDR_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] INST,
    output logic                  inst_mem_hazard,
    input  logic [ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                  cpu_data_mem_read,
    output logic [DATA_WIDTH-1:0] data_mem_rdata,
    input  logic [ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0] cpu_data_mem_wdata,
    input  logic                  cpu_data_mem_write,
    output logic                  data_mem_hazard,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  data_ok_q, data_ok_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  data_op;
    logic                  fill_en;
    logic                  inval_en;
    logic                  ibuf_hit;
    logic [DATA_WIDTH-1:0] ibuf_data;

    assign data_op         = cpu_data_mem_write | cpu_data_mem_read;
    assign inst_mem_hazard = !ibuf_hit;
    assign data_mem_hazard = data_op && !data_ok_q;
    assign INST            = ibuf_data;
    assign data_mem_rdata  = rdata_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

    inst_fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ibuf (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .fill_en    (fill_en),
        .fill_addr  (mem_addr_q),
        .fill_data  (mem_rdata),
        .inval_en   (inval_en),
        .inval_addr (mem_addr_q),
        .pc         (PC),
        .data       (ibuf_data),
        .hit        (ibuf_hit)
    );

    // Arbitration FSM next-state; data_ok only ever lives for one cycle, so a
    // retiring data op cannot be reissued and a fetch may use that IDLE slot.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_ok_d   = 1'b0;
        rdata_d     = rdata_q;
        fill_en     = 1'b0;
        inval_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_op && !data_ok_q) begin
                    state_d     = DATA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_data_mem_write;
                    mem_addr_d  = cpu_data_mem_write ? cpu_data_mem_waddr : cpu_data_mem_raddr;
                    mem_wdata_d = cpu_data_mem_wdata;
                end else if (inst_mem_hazard) begin
                    state_d    = INST_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = PC;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA_BUSY: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    data_ok_d = 1'b1;
                    inval_en  = mem_we_q;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = DATA_BUSY;
                end
            end
            INST_BUSY: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    fill_en   = 1'b1;
                end else begin
                    state_d = INST_BUSY;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // FSM and registered memory-side outputs with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            data_ok_q   <= 1'b0;
            rdata_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_ok_q   <= data_ok_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule
